// File: rtl/ccu_snoop_responder.sv
// Single-outstanding ACE snoop responder: AC capture -> tag lookup -> CR -> CD line stream -> state update.
// Optional feature macro CCU_SNOOP_CLEAN_DATA_EN: clean ReadShared/ReadClean/ReadNotSharedDirty hits also supply data.
module ccu_snoop_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int CD_BEATS   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        ac_valid_i,
    output logic                        ac_ready_o,
    input  logic [ADDR_WIDTH-1:0]       ac_addr_i,
    input  logic [3:0]                  ac_snoop_i,
    input  logic [2:0]                  ac_prot_i,
    output logic                        cr_valid_o,
    input  logic                        cr_ready_i,
    output logic [4:0]                  cr_resp_o,
    output logic                        cd_valid_o,
    input  logic                        cd_ready_i,
    output logic [DATA_WIDTH-1:0]       cd_data_o,
    output logic                        cd_last_o,
    output logic                        lookup_req_o,
    output logic [ADDR_WIDTH-1:0]       lookup_addr_o,
    output logic [2:0]                  lookup_prot_o,
    input  logic                        lookup_valid_i,
    input  logic                        lookup_hit_i,
    input  logic                        lookup_dirty_i,
    input  logic                        lookup_unique_i,
    output logic                        data_req_o,
    output logic [$clog2(CD_BEATS)-1:0] data_beat_o,
    input  logic                        data_valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        upd_valid_o,
    input  logic                        upd_ready_i,
    output logic [ADDR_WIDTH-1:0]       upd_addr_o,
    output logic                        upd_invalidate_o,
    output logic                        upd_clean_o,
    output logic                        upd_shared_o
);
    localparam int BW = $clog2(CD_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(CD_BEATS - 1);
`ifdef CCU_SNOOP_CLEAN_DATA_EN
    localparam logic CLEAN_DATA_EN = 1'b1;
`else
    localparam logic CLEAN_DATA_EN = 1'b0;
`endif

    // cr_resp bit positions
    localparam int RESP_DT = 0, RESP_ERR = 1, RESP_PD = 2, RESP_IS = 3, RESP_WU = 4;

    localparam logic [3:0] SNP_READ_ONCE   = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN  = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD    = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHRD  = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INV   = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INV    = 4'b1101;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CR, S_CD, S_UPDATE} state_e;

    state_e                  r_state, w_state_nxt;
    logic                    r_alive;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_snoop;
    logic [2:0]              r_prot;
    logic                    r_hit, r_dirty, r_unique;

    logic [BW-1:0]           r_req_beat, r_out_beat;
    logic                    r_req_done, r_pend;
    logic [1:0]              r_occ;
    logic                    r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_buf [2];

    logic [4:0]              w_resp;
    logic                    w_upd_inv, w_upd_clean, w_upd_shared, w_upd_needed;
    logic                    w_cd_active, w_cd_valid, w_cd_fire, w_push, w_pop, w_issue, w_last_beat;
    logic [1:0]              w_inflight;
    logic [DATA_WIDTH-1:0]   w_cd_head;

    // Response and state-change decode from the captured snoop and lookup result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_resp       = '0;
        w_upd_inv    = 1'b0;
        w_upd_clean  = 1'b0;
        w_upd_shared = 1'b0;
        case (r_snoop)
            SNP_READ_ONCE: if (r_hit) begin
                w_resp[RESP_DT] = 1'b1;
                w_resp[RESP_IS] = 1'b1;
                w_resp[RESP_WU] = r_unique;
            end
            SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: if (r_hit) begin
                w_resp[RESP_DT] = r_dirty | CLEAN_DATA_EN;
                w_resp[RESP_PD] = r_dirty;
                w_resp[RESP_IS] = 1'b1;
                w_resp[RESP_WU] = r_unique;
                w_upd_shared    = 1'b1;
                w_upd_clean     = r_dirty;
            end
            SNP_READ_UNIQUE: if (r_hit) begin
                w_resp[RESP_DT] = 1'b1;
                w_resp[RESP_PD] = r_dirty;
                w_resp[RESP_WU] = r_unique;
                w_upd_inv       = 1'b1;
            end
            SNP_CLEAN_INV: if (r_hit) begin
                w_resp[RESP_DT] = r_dirty;
                w_resp[RESP_PD] = r_dirty;
                w_upd_inv       = 1'b1;
            end
            SNP_CLEAN_SHRD: if (r_hit) begin
                w_resp[RESP_DT] = r_dirty;
                w_resp[RESP_PD] = r_dirty;
                w_resp[RESP_IS] = 1'b1;
                w_upd_clean     = r_dirty;
            end
            SNP_MAKE_INV: if (r_hit) w_upd_inv = 1'b1;
            default: w_resp[RESP_ERR] = 1'b1;
        endcase
        w_upd_needed = w_upd_inv | w_upd_clean | w_upd_shared;
    end

    // CD path: a freshly returned beat bypasses the empty buffer so beat 0 appears one cycle after its request.
    assign w_cd_active = (r_state == S_CD);
    assign w_cd_head   = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : data_i;
    assign w_cd_valid  = w_cd_active && ((r_occ != 2'd0) || data_valid_i);
    assign w_cd_fire   = w_cd_valid && cd_ready_i;
    assign w_pop       = w_cd_fire && (r_occ != 2'd0);
    assign w_push      = w_cd_active && data_valid_i && !((r_occ == 2'd0) && cd_ready_i);
    assign w_inflight  = r_occ + {1'b0, r_pend};
    assign w_issue     = w_cd_active && !r_req_done && (w_inflight < 2'd2);
    assign w_last_beat = (r_out_beat == LAST_BEAT);

    assign cd_valid_o    = w_cd_valid;
    assign cd_data_o     = w_cd_valid ? w_cd_head : '0;
    assign cd_last_o     = w_cd_valid && w_last_beat;
    assign data_req_o    = w_issue;
    assign data_beat_o   = r_req_beat;
    assign lookup_addr_o = r_addr;
    assign lookup_prot_o = r_prot;
    assign upd_addr_o    = r_addr;

    always_comb begin
        w_state_nxt      = r_state;
        ac_ready_o       = 1'b0;
        lookup_req_o     = 1'b0;
        cr_valid_o       = 1'b0;
        cr_resp_o        = '0;
        upd_valid_o      = 1'b0;
        upd_invalidate_o = 1'b0;
        upd_clean_o      = 1'b0;
        upd_shared_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ac_ready_o = r_alive;
                if (ac_valid_i && r_alive) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                lookup_req_o = 1'b1;
                if (lookup_valid_i) w_state_nxt = S_CR;
            end
            S_CR: begin
                cr_valid_o = 1'b1;
                cr_resp_o  = w_resp;
                if (cr_ready_i)
                    w_state_nxt = w_resp[RESP_DT] ? S_CD : (w_upd_needed ? S_UPDATE : S_IDLE);
            end
            S_CD: if (w_cd_fire && w_last_beat) w_state_nxt = w_upd_needed ? S_UPDATE : S_IDLE;
            S_UPDATE: begin
                upd_valid_o      = 1'b1;
                upd_invalidate_o = w_upd_inv;
                upd_clean_o      = w_upd_clean;
                upd_shared_o     = w_upd_shared;
                if (upd_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_alive  <= 1'b0;
            r_addr   <= '0;
            r_snoop  <= '0;
            r_prot   <= '0;
            r_hit    <= 1'b0;
            r_dirty  <= 1'b0;
            r_unique <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            if (ac_valid_i && ac_ready_o) begin
                r_addr  <= ac_addr_i;
                r_snoop <= ac_snoop_i;
                r_prot  <= ac_prot_i;
            end
            if (lookup_req_o && lookup_valid_i) begin
                r_hit    <= lookup_hit_i;
                r_dirty  <= lookup_dirty_i;
                r_unique <= lookup_unique_i;
            end
        end
    end

    // Beat sequencing and buffer bookkeeping restart whenever the FSM is outside CD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_beat <= '0;
            r_req_done <= 1'b0;
            r_pend     <= 1'b0;
            r_out_beat <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else if (!w_cd_active) begin
            r_req_beat <= '0;
            r_req_done <= 1'b0;
            r_pend     <= 1'b0;
            r_out_beat <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_req_beat <= r_req_beat + BW'(1);
                if (r_req_beat == LAST_BEAT) r_req_done <= 1'b1;
            end
            if (w_cd_fire) r_out_beat <= r_out_beat + BW'(1);
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
        end
    end

    // NOTE: buffer storage has no reset; r_occ alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_push) r_buf[r_wr_ptr] <= data_i;
    end
endmodule
